// File: rtl/time_set_ctrl.sv
// Mode/set controller for the clock display: turns button pulses and the 1 Hz tick into
// per-field increment/clear pulses and blink enables. Optional SET_SEC field via SECONDS_SET_EN.
module time_set_ctrl #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ena,
  input  logic       i_tick_1hz,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  output logic       o_inc_sec,
  output logic       o_inc_min,
  output logic       o_inc_hr,
  output logic       o_clr_sec,
  output logic       o_blank_hr,
  output logic       o_blank_min,
  output logic       o_blank_sec,
  output logic [1:0] o_mode
);

  localparam int DIV_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_SET_SEC = 2'b11
  } state_t;

  state_t              state_q, state_d, field_nxt;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                phase_q, phase_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                inc_sec_q, inc_sec_d;
  logic                inc_min_q, inc_min_d;
  logic                inc_hr_q, inc_hr_d;
  logic                clr_sec_q, clr_sec_d;
  logic                in_set, timeout, restart_blink;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_RUN;
      div_q     <= '0;
      phase_q   <= 1'b0;
      idle_q    <= '0;
      inc_sec_q <= 1'b0;
      inc_min_q <= 1'b0;
      inc_hr_q  <= 1'b0;
      clr_sec_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      idle_q    <= idle_d;
      inc_sec_q <= inc_sec_d;
      inc_min_q <= inc_min_d;
      inc_hr_q  <= inc_hr_d;
      clr_sec_q <= clr_sec_d;
    end
  end

  always_comb begin
    unique case (state_q)
      ST_RUN:     field_nxt = ST_SET_HR;
      ST_SET_HR:  field_nxt = ST_SET_MIN;
`ifdef SECONDS_SET_EN
      ST_SET_MIN: field_nxt = ST_SET_SEC;
`else
      ST_SET_MIN: field_nxt = ST_RUN;
`endif
      default:    field_nxt = ST_RUN;
    endcase
  end

  // An inc press counts as activity, so it cancels a timeout landing on the same tick;
  // a mode press does not, and the timeout's return to RUN takes precedence.
  assign in_set  = (state_q != ST_RUN);
  assign timeout = in_set && i_tick_1hz && !i_btn_inc && (idle_q == IDLE_W'(TIMEOUT_S - 1));

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    phase_d       = phase_q;
    idle_d        = idle_q;
    inc_sec_d     = 1'b0;
    inc_min_d     = 1'b0;
    inc_hr_d      = 1'b0;
    clr_sec_d     = 1'b0;
    restart_blink = 1'b0;
    if (i_ena) begin
      if (div_q == DIV_W'(BLINK_DIV - 1)) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + 1'b1;
      end
      if (!in_set) begin
        inc_sec_d = i_tick_1hz;
        idle_d    = '0;
        if (i_btn_mode) state_d = ST_SET_HR;
        restart_blink = i_btn_mode | i_btn_inc;
      end else if (timeout || (i_btn_mode && field_nxt == ST_RUN)) begin
        state_d       = ST_RUN;
        clr_sec_d     = (state_q != ST_SET_SEC);
        idle_d        = '0;
        restart_blink = 1'b1;
      end else if (i_btn_mode) begin
        state_d       = field_nxt;
        idle_d        = '0;
        restart_blink = 1'b1;
      end else if (i_btn_inc) begin
        inc_hr_d      = (state_q == ST_SET_HR);
        inc_min_d     = (state_q == ST_SET_MIN);
        clr_sec_d     = (state_q == ST_SET_SEC);
        idle_d        = '0;
        restart_blink = 1'b1;
      end else if (i_tick_1hz) begin
        idle_d = idle_q + 1'b1;
      end
      if (restart_blink) begin
        div_d   = '0;
        phase_d = 1'b0;
      end
    end
  end

  assign o_inc_sec   = inc_sec_q;
  assign o_inc_min   = inc_min_q;
  assign o_inc_hr    = inc_hr_q;
  assign o_clr_sec   = clr_sec_q;
  assign o_mode      = state_q;
  assign o_blank_hr  = phase_q & (state_q == ST_SET_HR);
  assign o_blank_min = phase_q & (state_q == ST_SET_MIN);
`ifdef SECONDS_SET_EN
  assign o_blank_sec = phase_q & (state_q == ST_SET_SEC);
`else
  assign o_blank_sec = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl (default build, SECONDS_SET_EN undefined): vector table,
// corner-case sequences and random stimulus against a behavioural model.
module tb_time_set_ctrl;

  localparam int BD = 4;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1, i_ena = 1'b0, i_tick_1hz = 1'b0, i_btn_mode = 1'b0, i_btn_inc = 1'b0;
  logic       o_inc_sec, o_inc_min, o_inc_hr, o_clr_sec;
  logic       o_blank_hr, o_blank_min, o_blank_sec;
  logic [1:0] o_mode;

  time_set_ctrl #(.BLINK_DIV(BD), .TIMEOUT_S(TO)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ena(i_ena), .i_tick_1hz(i_tick_1hz),
    .i_btn_mode(i_btn_mode), .i_btn_inc(i_btn_inc),
    .o_inc_sec(o_inc_sec), .o_inc_min(o_inc_min), .o_inc_hr(o_inc_hr), .o_clr_sec(o_clr_sec),
    .o_blank_hr(o_blank_hr), .o_blank_min(o_blank_min), .o_blank_sec(o_blank_sec),
    .o_mode(o_mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: field index, ticks since last activity, cycles since blink restart.
  int   m_mode = 0;
  int   m_idle = 0;
  int   m_since = 0;
  logic em_isec = 0, em_imin = 0, em_ihr = 0, em_clr = 0;

  function automatic int next_field(input int f);
`ifdef SECONDS_SET_EN
    return (f + 1) % 4;
`else
    return (f + 1) % 3;
`endif
  endfunction

  task automatic model_step(input logic r, e, t, m, n);
    int nxt;
    em_isec = 0; em_imin = 0; em_ihr = 0; em_clr = 0;
    if (r) begin
      m_mode = 0; m_idle = 0; m_since = 0;
    end else if (e) begin
      if (m_mode == 0) begin
        if (t) em_isec = 1;
        if (m) begin m_mode = 1; m_idle = 0; end
        if (m || n) m_since = 0; else m_since = (m_since + 1) % (2 * BD);
      end else begin
        nxt = next_field(m_mode);
        if ((t && !n && m_idle + 1 >= TO) || (m && nxt == 0)) begin
          em_clr = (m_mode != 3);
          m_mode = 0; m_idle = 0; m_since = 0;
        end else if (m) begin
          m_mode = nxt; m_idle = 0; m_since = 0;
        end else if (n) begin
          em_ihr = (m_mode == 1); em_imin = (m_mode == 2); em_clr = (m_mode == 3);
          m_idle = 0; m_since = 0;
        end else begin
          if (t) m_idle++;
          m_since = (m_since + 1) % (2 * BD);
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic ph;
    ph = ((m_since / BD) % 2) == 1;
    chk({tag, ".inc_sec"}, {1'b0, o_inc_sec}, {1'b0, em_isec});
    chk({tag, ".inc_min"}, {1'b0, o_inc_min}, {1'b0, em_imin});
    chk({tag, ".inc_hr"},  {1'b0, o_inc_hr},  {1'b0, em_ihr});
    chk({tag, ".clr_sec"}, {1'b0, o_clr_sec}, {1'b0, em_clr});
    chk({tag, ".mode"}, o_mode, 2'(m_mode));
    chk({tag, ".blank_hr"},  {1'b0, o_blank_hr},  {1'b0, ph && m_mode == 1});
    chk({tag, ".blank_min"}, {1'b0, o_blank_min}, {1'b0, ph && m_mode == 2});
    chk({tag, ".blank_sec"}, {1'b0, o_blank_sec}, {1'b0, ph && m_mode == 3});
  endtask

  // Drive one cycle of inputs, let the edge pass, then sample 1 ns later.
  task automatic step(input logic r, e, t, m, n);
    i_reset = r; i_ena = e; i_tick_1hz = t; i_btn_mode = m; i_btn_inc = n;
    @(posedge clk);
    #1;
    model_step(r, e, t, m, n);
  endtask

  task automatic idle_cyc();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [4:0] in;   // {reset, ena, tick, mode, inc}
    logic [3:0] pul;  // {inc_sec, inc_min, inc_hr, clr_sec}
    logic [1:0] md;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] in, input logic [3:0] pul, input logic [1:0] md);
    vec_t v;
    v.in = in; v.pul = pul; v.md = md;
    vecs.push_back(v);
  endtask

  int clr_cnt;

  initial begin
    // reset and RUN ticks
    add(5'b11000, 4'b0000, 2'd0);
    add(5'b01100, 4'b1000, 2'd0);
    add(5'b01000, 4'b0000, 2'd0);
    add(5'b01100, 4'b1000, 2'd0);
    add(5'b01100, 4'b1000, 2'd0);
    add(5'b01001, 4'b0000, 2'd0);
    add(5'b01100, 4'b1000, 2'd0);
    // mode, inc x3 (one with a tick), mode, inc x2, mode
    add(5'b01010, 4'b0000, 2'd1);
    add(5'b01001, 4'b0010, 2'd1);
    add(5'b01001, 4'b0010, 2'd1);
    add(5'b01101, 4'b0010, 2'd1);
    add(5'b01010, 4'b0000, 2'd2);
    add(5'b01001, 4'b0100, 2'd2);
    add(5'b01001, 4'b0100, 2'd2);
    add(5'b01010, 4'b0001, 2'd0);
    add(5'b01000, 4'b0000, 2'd0);
    // SET_MIN with mode+inc together
    add(5'b01010, 4'b0000, 2'd1);
    add(5'b01010, 4'b0000, 2'd2);
    add(5'b01011, 4'b0001, 2'd0);
    add(5'b01000, 4'b0000, 2'd0);
    // enable low drops inputs; reset mid-SET
    add(5'b00100, 4'b0000, 2'd0);
    add(5'b00010, 4'b0000, 2'd0);
    add(5'b01010, 4'b0000, 2'd1);
    add(5'b00001, 4'b0000, 2'd1);
    add(5'b00010, 4'b0000, 2'd1);
    add(5'b00100, 4'b0000, 2'd1);
    add(5'b01001, 4'b0010, 2'd1);
    add(5'b11001, 4'b0000, 2'd0);
    add(5'b01000, 4'b0000, 2'd0);
    // tick and mode together in RUN still advance seconds
    add(5'b01110, 4'b1000, 2'd1);
    add(5'b11000, 4'b0000, 2'd0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (vecs[i]) begin
      step(vecs[i].in[4], vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
      chk($sformatf("vec%0d.inc_sec", i), {1'b0, o_inc_sec}, {1'b0, vecs[i].pul[3]});
      chk($sformatf("vec%0d.inc_min", i), {1'b0, o_inc_min}, {1'b0, vecs[i].pul[2]});
      chk($sformatf("vec%0d.inc_hr", i),  {1'b0, o_inc_hr},  {1'b0, vecs[i].pul[1]});
      chk($sformatf("vec%0d.clr_sec", i), {1'b0, o_clr_sec}, {1'b0, vecs[i].pul[0]});
      chk($sformatf("vec%0d.mode", i), o_mode, vecs[i].md);
    end

    // Timeout: 10 idle ticks in SET_HR return to RUN with one seconds clear
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    clr_cnt = 0;
    for (int k = 1; k <= TO; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("timeout.no_inc_sec", {1'b0, o_inc_sec}, 2'd0);
      chk("timeout.mode", o_mode, (k < TO) ? 2'd1 : 2'd0);
      clr_cnt += o_clr_sec;
      idle_cyc();
      clr_cnt += o_clr_sec;
    end
    chk("timeout.clr_count", 2'(clr_cnt), 2'd1);

    // Timeout and mode press on the same cycle: a single return to RUN
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < TO; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tmo_mode.pre_mode", o_mode, 2'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("tmo_mode.mode", o_mode, 2'd0);
    chk("tmo_mode.clr", {1'b0, o_clr_sec}, 2'd1);
    idle_cyc();
    chk("tmo_mode.clr_once", {1'b0, o_clr_sec}, 2'd0);
    chk("tmo_mode.stay_run", o_mode, 2'd0);

    // Blink: 4 cycles shown, 4 blanked; an inc press restarts with digits shown
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("blink.c0", {1'b0, o_blank_hr}, 2'd0);
    for (int i = 1; i <= 2 * BD; i++) begin
      idle_cyc();
      chk($sformatf("blink.c%0d", i), {1'b0, o_blank_hr}, {1'b0, ((i / BD) % 2) == 1});
      chk("blink.min_off", {1'b0, o_blank_min}, 2'd0);
    end
    for (int i = 0; i < BD; i++) idle_cyc();
    chk("blink.pre_inc", {1'b0, o_blank_hr}, 2'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("blink.inc_shown", {1'b0, o_blank_hr}, 2'd0);
    chk("blink.inc_hr", {1'b0, o_inc_hr}, 2'd1);
    for (int i = 1; i < BD; i++) idle_cyc();
    chk("blink.restart_shown", {1'b0, o_blank_hr}, 2'd0);
    idle_cyc();
    chk("blink.restart_blank", {1'b0, o_blank_hr}, 2'd1);
    chk("blink.sec_off", {1'b0, o_blank_sec}, 2'd0);

    // Random stimulus against the model; alternate busy and quiet segments so timeouts occur
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_model("rnd_reset");
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic r, e, t, m, n;
      bit quiet;
      quiet = ((cyc / 500) % 2) == 1;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 9) != 0);
      t = ($urandom_range(0, 2) == 0);
      m = quiet ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 9) == 0);
      n = quiet ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 4) == 0);
      step(r, e, t, m, n);
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
